lamp_switch_ctrl: RTL
=====================

// Module: lamp_switch_ctrl
// PURPOSE
//   Sequential controller for the three-switch stairwell lamp. Synchronises and
//   debounces raw switch inputs, turns each odd-parity change into a lamp toggle,
//   and switches the lamp off after an inactivity timeout. It replaces direct
//   combinational parity drive of F with a clocked, glitch-free lamp output.
// PARAMETERS
//   N_SW        3     number of switch inputs (1..8)
//   DEB_CYCLES  4     consecutive cycles a synced level must differ before it is accepted (>=1)
//   TIMEOUT     1000  ON cycles with no switch activity before auto-off; 0 = auto-off disabled
//   TMR_W       16    timer width; TIMEOUT must fit in TMR_W bits
// PORTS
//   clk            in   1      system clock, rising edge
//   rst_n          in   1      asynchronous active-low reset
//   sw             in   N_SW   raw switch levels, asynchronous to clk, may bounce
//   lamp           out  1      lamp drive (F); 1 = on
//   sw_stable      out  N_SW   debounced switch levels
//   toggle_pulse   out  1      1-cycle strobe, lamp toggled this cycle
//   timeout_pulse  out  1      1-cycle strobe, lamp turned off by timeout
// BEHAVIOUR
//   Reset (async assert, sync release): sync flops, debounce counters, sw_stable,
//     lamp, timer, toggle_pulse, timeout_pulse all 0; FSM = OFF.
//   Sync: 2-flop synchroniser per bit; sync2 is the only value used downstream.
//   Debounce per bit: cnt increments each cycle sync2 != sw_stable; clears to 0 when
//     equal; when cnt == DEB_CYCLES-1 and still differing: sw_stable <= sync2, cnt <= 0.
//   Change event: chg = sw_stable XOR sw_stable_d (registered previous value).
//     odd  = ^chg -> toggle event; any = |chg -> activity event.
//   Latency: new level first sampled at edge k -> sw_stable updates at edge
//     k+1+DEB_CYCLES -> lamp/toggle_pulse update at edge k+2+DEB_CYCLES.
//   FSM OFF/ON (lamp = 1 iff ON):
//     OFF: toggle -> ON, timer <= 0, toggle_pulse.
//     ON : toggle -> OFF, toggle_pulse, timer <= 0.
//          else any (even-count change) -> stay ON, timer <= 0 (retrigger).
//          else TIMEOUT!=0 and timer == TIMEOUT-1 -> OFF, timer <= 0, timeout_pulse.
//          else timer <= timer+1 (saturates at all-ones; unreachable when TIMEOUT valid).
//   Simultaneous toggle and timeout expiry: toggle wins; lamp goes OFF via toggle,
//     toggle_pulse=1, timeout_pulse=0. Never both pulses in one cycle.
//   Simultaneous changes on several bits in one cycle: handled by parity only;
//     2 changes = no toggle (timer retrigger), 3 changes = one toggle.
//   Switches high at reset release: debounce accepts them as changes and toggles
//     normally (parity of held-high switches defines first lamp state).
//   TIMEOUT==0: timer held at 0, timeout_pulse never asserted.
//   Reset mid-debounce or mid-timeout: everything returns to reset values at once;
//     no pulse emitted on release.
// TESTING (DEB_CYCLES=4, TIMEOUT=20 unless noted)
//   T1 reset: rst_n=0 with sw=3'b000 -> lamp=0, sw_stable=0, both pulses 0 for all cycles.
//   T2 single switch: sw[0] 0->1 clean, first sampled at edge k -> sw_stable[0]=1 at
//      k+5, lamp=1 and toggle_pulse=1 at k+6 only; sw[0] 1->0 later -> lamp=0.
//   T3 bounce: sw[1] high for 3 cycles then low -> sw_stable, lamp, pulses unchanged;
//      high for 5 cycles -> accepted, lamp toggles.
//   T4 parity: sw[0],sw[1] change same cycle -> no toggle, ON timer restarts (lamp stays
//      on 20 cycles after that event); sw 000->111 same cycle -> exactly one toggle.
//   T5 timeout: lamp on at edge t, no activity -> lamp=0, timeout_pulse=1 at edge t+20;
//      with TIMEOUT=0 lamp stays on 200 cycles; toggle landing on expiry cycle -> only
//      toggle_pulse.
//   T6 reset mid-operation: rst_n low during debounce count 2 and at timer=10 -> all
//      outputs 0 immediately, no spurious pulse after release with sw=0.

Source files
------------

// File: rtl/lamp_switch_ctrl_if.sv
// Switch/lamp signal bundle for the stairwell lamp controller.
// The controller sits on the slave side; the switch panel and lamp driver sit on the master side.
interface lamp_switch_ctrl_if #(
  parameter int unsigned N_SW = 3
);
  logic [N_SW-1:0] sw;
  logic            lamp;
  logic [N_SW-1:0] sw_stable;
  logic            toggle_pulse;
  logic            timeout_pulse;

  modport master (
    output sw,
    input  lamp, sw_stable, toggle_pulse, timeout_pulse
  );

  modport slave (
    input  sw,
    output lamp, sw_stable, toggle_pulse, timeout_pulse
  );
endinterface

// File: rtl/lamp_switch_ctrl.sv
// Three-way stairwell lamp controller: synchronises and debounces the switches,
// toggles the lamp on each odd-parity change and turns it off after inactivity.
module lamp_switch_ctrl #(
  parameter int unsigned N_SW       = 3,
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1000,
  parameter int unsigned TMR_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  lamp_switch_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam bit               TMO_EN   = (TIMEOUT != 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [0:0] ST_OFF = 1'b0;
  localparam logic [0:0] ST_ON  = 1'b1;

  logic [N_SW-1:0]  sync1;
  logic [N_SW-1:0]  sync2;
  logic [N_SW-1:0]  sw_stable;
  logic [N_SW-1:0]  sw_stable_d;
  logic [CNT_W-1:0] deb_cnt [N_SW];

  logic [0:0]       state, state_nx;
  logic [TMR_W-1:0] timer, timer_nx;
  logic             toggle_pulse, toggle_nx;
  logic             timeout_pulse, timeout_nx;

  logic [N_SW-1:0]  chg;
  logic             odd;
  logic             any;

  // A level is accepted only after it has differed from sw_stable on DEB_CYCLES consecutive edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      sw_stable   <= '0;
      sw_stable_d <= '0;
      for (int unsigned i = 0; i < N_SW; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1       <= bus.sw;
      sync2       <= sync1;
      sw_stable_d <= sw_stable;
      for (int unsigned i = 0; i < N_SW; i++) begin
        if (sync2[i] == sw_stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_LAST) begin
          sw_stable[i] <= sync2[i];
          deb_cnt[i]   <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign chg = sw_stable ^ sw_stable_d;
  assign odd = ^chg;
  assign any = |chg;

  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    toggle_nx  = 1'b0;
    timeout_nx = 1'b0;
    case (state)
      ST_OFF: begin
        if (odd) begin
          state_nx  = ST_ON;
          timer_nx  = '0;
          toggle_nx = 1'b1;
        end
      end
      ST_ON: begin
        // Toggle has priority over expiry so both strobes never fire together.
        if (odd) begin
          state_nx  = ST_OFF;
          timer_nx  = '0;
          toggle_nx = 1'b1;
        end else if (any) begin
          timer_nx = '0;
        end else if (TMO_EN && (timer == TMR_LAST)) begin
          state_nx   = ST_OFF;
          timer_nx   = '0;
          timeout_nx = 1'b1;
        end else if (!TMO_EN) begin
          timer_nx = '0;
        end else if (timer != '1) begin
          timer_nx = timer + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_OFF;
      timer         <= '0;
      toggle_pulse  <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_nx;
      timer         <= timer_nx;
      toggle_pulse  <= toggle_nx;
      timeout_pulse <= timeout_nx;
    end
  end

  assign bus.lamp          = (state == ST_ON);
  assign bus.sw_stable     = sw_stable;
  assign bus.toggle_pulse  = toggle_pulse;
  assign bus.timeout_pulse = timeout_pulse;

endmodule
